// File: rtl/dm_sram_target_pkg.sv
// Shared types and constants for the rj32 data-memory to async-SRAM bridge.
package dm_sram_target_pkg;

    localparam int DM_AW   = 16;
    localparam int DM_DW   = 16;
    localparam int SRAM_AW = 18;

    localparam logic [DM_AW-1:0] BANK_ADR_DEF = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        ACK    = 3'd4
    } state_t;

endpackage

// File: rtl/dm_sram_target.sv
// Responder for the rj32 dm_* req/ack bus, driving a 256K x 16 asynchronous SRAM
// with programmable read/write wait states and a 2-bit bank register.
module dm_sram_target
    import dm_sram_target_pkg::*;
#(
    parameter int unsigned      WAIT_RD  = 2,
    parameter int unsigned      WAIT_WR  = 2,
    parameter logic [DM_AW-1:0] BANK_ADR = BANK_ADR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dm_req,
    input  logic               dm_we,
    input  logic [DM_AW-1:0]   dm_adr,
    input  logic [DM_DW-1:0]   dm_dat_i,
    output logic [DM_DW-1:0]   dm_dat_o,
    output logic               dm_ack,
    output logic [SRAM_AW-1:0] sram_adr,
    output logic [DM_DW-1:0]   sram_dat_o,
    input  logic [DM_DW-1:0]   sram_dat_i,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    localparam logic [3:0] WAIT_RD_C = 4'(WAIT_RD);
    localparam logic [3:0] WAIT_WR_C = 4'(WAIT_WR);

    state_t               state, state_nxt;
    logic [3:0]           cnt, cnt_nxt;
    logic                 we_q, we_q_nxt;
    logic [1:0]           bank, bank_nxt;
    logic [DM_DW-1:0]     dat_o_nxt;
    logic                 ack_nxt;
    logic [SRAM_AW-1:0]   adr_nxt;
    logic [DM_DW-1:0]     sdat_nxt;
    logic                 dq_oe_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt;

    logic is_bank;
    logic access_done;
    assign is_bank     = (dm_adr == BANK_ADR);
    assign access_done = (cnt == 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dm_req) state_nxt = is_bank ? ACK : SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (access_done) state_nxt = we_q ? HOLD : ACK;
            HOLD:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for every registered output; strobes only move on state changes.
    always_comb begin
        cnt_nxt   = cnt;
        we_q_nxt  = we_q;
        bank_nxt  = bank;
        dat_o_nxt = dm_dat_o;
        ack_nxt   = 1'b0;
        adr_nxt   = sram_adr;
        sdat_nxt  = sram_dat_o;
        dq_oe_nxt = sram_dq_oe;
        ce_n_nxt  = sram_ce_n;
        oe_n_nxt  = sram_oe_n;
        we_n_nxt  = sram_we_n;
        case (state)
            IDLE: begin
                if (dm_req) begin
                    we_q_nxt = dm_we;
                    if (is_bank) begin
                        if (dm_we) bank_nxt  = dm_dat_i[1:0];
                        else       dat_o_nxt = {{(DM_DW-2){1'b0}}, bank};
                        ack_nxt = 1'b1;
                    end else begin
                        adr_nxt  = {bank, dm_adr};
                        ce_n_nxt = 1'b0;
                        if (dm_we) begin
                            dq_oe_nxt = 1'b1;
                            sdat_nxt  = dm_dat_i;
                        end else begin
                            oe_n_nxt = 1'b0;
                        end
                    end
                end
            end
            SETUP: begin
                cnt_nxt = we_q ? WAIT_WR_C : WAIT_RD_C;
                if (we_q) we_n_nxt = 1'b0;
            end
            ACCESS: begin
                if (access_done) begin
                    if (we_q) begin
                        we_n_nxt = 1'b1;
                    end else begin
                        dat_o_nxt = sram_dat_i;
                        oe_n_nxt  = 1'b1;
                        ce_n_nxt  = 1'b1;
                        ack_nxt   = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            HOLD: begin
                dq_oe_nxt = 1'b0;
                ce_n_nxt  = 1'b1;
                ack_nxt   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            we_q       <= 1'b0;
            bank       <= '0;
            dm_dat_o   <= '0;
            dm_ack     <= 1'b0;
            sram_adr   <= '0;
            sram_dat_o <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            cnt        <= cnt_nxt;
            we_q       <= we_q_nxt;
            bank       <= bank_nxt;
            dm_dat_o   <= dat_o_nxt;
            dm_ack     <= ack_nxt;
            sram_adr   <= adr_nxt;
            sram_dat_o <= sdat_nxt;
            sram_dq_oe <= dq_oe_nxt;
            sram_ce_n  <= ce_n_nxt;
            sram_oe_n  <= oe_n_nxt;
            sram_we_n  <= we_n_nxt;
        end
    end

endmodule

// File: tb/tb_dm_sram_target.sv
// Scoreboard bench for dm_sram_target: bus transactions push expectations,
// the ack monitor pops and compares them against latency, data and strobe activity.
module tb_dm_sram_target;

    localparam int unsigned WAIT_RD = 2;
    localparam int unsigned WAIT_WR = 2;
    localparam logic [15:0] BANK_A  = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [15:0] dm_adr = '0;
    logic [15:0] dm_dat_i = '0;
    logic [15:0] dm_dat_o;
    logic        dm_ack;
    logic [17:0] sram_adr;
    logic [15:0] sram_dat_o;
    logic [15:0] sram_dat_i = '0;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    dm_sram_target #(.WAIT_RD(WAIT_RD), .WAIT_WR(WAIT_WR), .BANK_ADR(BANK_A)) dut (
        .clk(clk), .rst_n(rst_n),
        .dm_req(dm_req), .dm_we(dm_we), .dm_adr(dm_adr), .dm_dat_i(dm_dat_i),
        .dm_dat_o(dm_dat_o), .dm_ack(dm_ack),
        .sram_adr(sram_adr), .sram_dat_o(sram_dat_o), .sram_dat_i(sram_dat_i),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          start;
        int          lat;
        bit          is_bank;
        bit          we;
        logic [15:0] dat_o;
        logic [17:0] adr;
        logic [15:0] wdat;
        int          n_we, n_oe, n_ce, n_dq;
    } item_t;

    item_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Asynchronous SRAM model; unwritten locations read as DEAD.
    logic [15:0] mem [logic [17:0]];
    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) mem[sram_adr] = sram_dat_o;
        if (!sram_ce_n && !sram_oe_n)
            sram_dat_i = mem.exists(sram_adr) ? mem[sram_adr] : 16'hDEAD;
        else
            sram_dat_i = 16'h0000;
    end

    int          c_we, c_oe, c_ce, c_dq;
    logic [17:0] last_adr;
    logic [15:0] last_wdat;
    logic        prev_ack;

    always @(negedge clk) begin
        item_t it;
        if (!rst_n) begin
            c_we = 0; c_oe = 0; c_ce = 0; c_dq = 0;
            prev_ack = 1'b0;
        end else begin
            chk("we_oe_excl", 32'(!sram_we_n && !sram_oe_n), 32'd0);
            chk("dq_oe_excl", 32'(sram_dq_oe && !sram_oe_n), 32'd0);
            if (!sram_we_n) begin c_we++; last_wdat = sram_dat_o; end
            if (!sram_oe_n) c_oe++;
            if (sram_dq_oe) c_dq++;
            if (!sram_ce_n) begin c_ce++; last_adr = sram_adr; end
            if (dm_ack) begin
                chk("ack_width", 32'(prev_ack), 32'd0);
                if (sb.size() == 0) begin
                    chk("spurious_ack", 32'd1, 32'd0);
                end else begin
                    it = sb.pop_front();
                    chk("latency", 32'(cyc - it.start), 32'(it.lat));
                    chk("dm_dat_o", 32'(dm_dat_o), 32'(it.dat_o));
                    chk("we_cycles", 32'(c_we), 32'(it.n_we));
                    chk("oe_cycles", 32'(c_oe), 32'(it.n_oe));
                    chk("ce_cycles", 32'(c_ce), 32'(it.n_ce));
                    chk("dq_cycles", 32'(c_dq), 32'(it.n_dq));
                    if (!it.is_bank) chk("sram_adr", 32'(last_adr), 32'(it.adr));
                    if (!it.is_bank && it.we) chk("sram_wdat", 32'(last_wdat), 32'(it.wdat));
                end
                c_we = 0; c_oe = 0; c_ce = 0; c_dq = 0;
            end
            prev_ack = dm_ack;
        end
    end

    logic [15:0] exp_dat_o = '0;

    // Called just after a negedge; returns at the negedge where dm_ack is seen, req still high.
    task automatic txn(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                       input logic [15:0] exp_rd, input logic [17:0] exp_adr,
                       input int extra, input bit drop);
        item_t it;
        int    n;
        it.is_bank = (adr == BANK_A);
        it.we      = we;
        it.adr     = exp_adr;
        it.wdat    = dat;
        if (!we) exp_dat_o = exp_rd;
        it.dat_o   = exp_dat_o;
        it.n_we = 0; it.n_oe = 0; it.n_ce = 0; it.n_dq = 0;
        if (it.is_bank) begin
            it.lat = 1;
        end else if (we) begin
            it.lat  = int'(WAIT_WR) + 3;
            it.n_we = int'(WAIT_WR);
            it.n_ce = int'(WAIT_WR) + 2;
            it.n_dq = int'(WAIT_WR) + 2;
        end else begin
            it.lat  = int'(WAIT_RD) + 2;
            it.n_oe = int'(WAIT_RD) + 1;
            it.n_ce = int'(WAIT_RD) + 1;
        end
        it.lat   = it.lat + extra;
        it.start = cyc;
        sb.push_back(it);
        dm_req = 1'b1; dm_we = we; dm_adr = adr; dm_dat_i = dat;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (drop && n == 2) begin
                dm_req = 1'b0; dm_we = 1'b1; dm_adr = BANK_A; dm_dat_i = 16'h0002;
            end
        end while (!dm_ack && n < 40);
        if (!dm_ack) chk("ack_timeout", 32'd1, 32'd0);
    endtask

    task automatic gap();
        dm_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ack",   32'(dm_ack),     32'd0);
        chk("rst_dat_o", 32'(dm_dat_o),   32'd0);
        chk("rst_adr",   32'(sram_adr),   32'd0);
        chk("rst_sdat",  32'(sram_dat_o), 32'd0);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_ce_n",  32'(sram_ce_n),  32'd1);
        chk("rst_oe_n",  32'(sram_oe_n),  32'd1);
        chk("rst_we_n",  32'(sram_we_n),  32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        txn(1'b1, 16'h0123, 16'hBEEF, 16'h0, 18'h00123, 0, 1'b0); gap();
        txn(1'b0, 16'h0123, 16'h0,    16'hBEEF, 18'h00123, 0, 1'b0); gap();
        txn(1'b1, BANK_A,   16'h0003, 16'h0, 18'h0, 0, 1'b0); gap();
        txn(1'b1, 16'h0010, 16'h1234, 16'h0, 18'h30010, 0, 1'b0); gap();
        txn(1'b0, 16'h0010, 16'h0,    16'h1234, 18'h30010, 0, 1'b0); gap();
        txn(1'b0, BANK_A,   16'h0,    16'h0003, 18'h0, 0, 1'b0); gap();

        // back-to-back: req stays high across the first ack
        txn(1'b1, 16'h0040, 16'h5A5A, 16'h0, 18'h30040, 0, 1'b0);
        txn(1'b0, 16'h0040, 16'h0,    16'h5A5A, 18'h30040, 1, 1'b0); gap();

        // reset in the middle of a write access
        dm_req = 1'b1; dm_we = 1'b1; dm_adr = 16'h0200; dm_dat_i = 16'h1111;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we_n",  32'(sram_we_n),  32'd1);
        chk("mid_rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("mid_rst_ce_n",  32'(sram_ce_n),  32'd1);
        chk("mid_rst_ack",   32'(dm_ack),     32'd0);
        dm_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_dat_o = 16'h0;
        repeat (5) @(negedge clk);

        txn(1'b0, BANK_A,   16'h0, 16'h0000, 18'h0, 0, 1'b0); gap();
        txn(1'b0, 16'h0123, 16'h0, 16'hBEEF, 18'h00123, 0, 1'b0); gap();
        txn(1'b1, 16'h0050, 16'hC3C3, 16'h0, 18'h00050, 0, 1'b0); gap();

        // req dropped during read access: must still complete exactly once
        txn(1'b0, 16'h0050, 16'h0, 16'hC3C3, 18'h00050, 0, 1'b1); gap();
        txn(1'b0, BANK_A,   16'h0, 16'h0000, 18'h0, 0, 1'b0); gap();
        repeat (6) @(negedge clk);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
